// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller for the SAR-ADC model.
// Samples the input, strobes the comparator once per bit (MSB first),
// steers the binary-weighted cap-DAC from the trial code and publishes
// the resolved code with a one-cycle valid pulse.
module sar_logic #(
   parameter int NBITS         = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int TIMEOUT       = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vop,
   input  logic             done,
   output logic             asyn_clk,
   output logic             sample,
   output logic [NBITS-1:0] dac_p,
   output logic [NBITS-1:0] dac_n,
   output logic [NBITS-1:0] dout,
   output logic             valid,
   output logic             busy,
   output logic             timeout_err
);

   localparam int CMAX = (TIMEOUT > SAMPLE_CYCLES) ? TIMEOUT : SAMPLE_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(NBITS);
   localparam logic [NBITS-1:0] MSB_CODE = {1'b1, {(NBITS-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      SAMPLE,
      COMP_HI,
      COMP_LO,
      FINISH
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   bit_idx;

   logic            done_m;
   logic            done_s;
   logic            done_d;
   logic            done_rise;
   logic            done_fall;
   logic            hi_exit;
   logic            lo_exit;
   logic            cur_bit;
   logic [NBITS-1:0] res_code;

   // Two-flop synchronizer for the comparator's done flag, plus one delay
   // stage so the FSM can act on edges of the synchronized flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_m <= 1'b0;
         done_s <= 1'b0;
         done_d <= 1'b0;
      end else begin
         done_m <= done;
         done_s <= done_m;
         done_d <= done_s;
      end
   end

   // Waits are edge-qualified: a comparator that never answers leaves no
   // falling edge either, so both halves of the bit run into the timeout.
   assign done_rise = done_s & ~done_d;
   assign done_fall = ~done_s & done_d;
   assign hi_exit   = done_rise || (cnt == CW'(TIMEOUT - 1));
   assign lo_exit   = done_fall || (cnt == CW'(TIMEOUT - 1));

   // Resolved trial code: current bit takes the decision (0 on timeout),
   // the next lower bit is set for the following trial.
   always_comb begin
      cur_bit           = done_rise ? vop : 1'b0;
      res_code          = dac_p;
      res_code[bit_idx] = cur_bit;
      if (bit_idx != '0) begin
         res_code[bit_idx - IW'(1)] = 1'b1;
      end
   end

   // Conversion sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         dac_p       <= '0;
         dac_n       <= '1;
         dout        <= '0;
         asyn_clk    <= 1'b0;
         sample      <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SAMPLE;
                  sample      <= 1'b1;
                  busy        <= 1'b1;
                  timeout_err <= 1'b0;
                  dac_p       <= MSB_CODE;
                  dac_n       <= ~MSB_CODE;
                  bit_idx     <= IW'(NBITS - 1);
                  cnt         <= '0;
               end
            end
            SAMPLE: begin
               if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
                  state    <= COMP_HI;
                  sample   <= 1'b0;
                  asyn_clk <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            COMP_HI: begin
               if (hi_exit) begin
                  dac_p    <= res_code;
                  dac_n    <= ~res_code;
                  asyn_clk <= 1'b0;
                  cnt      <= '0;
                  state    <= COMP_LO;
                  if (!done_rise) begin
                     timeout_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            COMP_LO: begin
               if (lo_exit) begin
                  cnt <= '0;
                  if (!done_fall) begin
                     timeout_err <= 1'b1;
                  end
                  if (bit_idx != '0) begin
                     bit_idx  <= bit_idx - IW'(1);
                     asyn_clk <= 1'b1;
                     state    <= COMP_HI;
                  end else begin
                     state <= FINISH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FINISH: begin
               dout  <= dac_p;
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobe and sample switch must never overlap; valid ends the busy window.
   a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(asyn_clk && sample));
   a_valid_idle: assert property (@(posedge clk) disable iff (rst) valid |-> !busy);

endmodule

// File: tb/tb_sar_logic.sv
// Directed testbench for sar_logic with an ideal behavioural comparator.
module tb_sar_logic;

   logic       clk;
   logic       rst;
   logic       start;
   logic       vop;
   logic       done;
   logic       asyn_clk;
   logic       sample;
   logic [7:0] dac_p;
   logic [7:0] dac_n;
   logic [7:0] dout;
   logic       valid;
   logic       busy;
   logic       timeout_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int strobe_cnt   = 0;
   int vin          = 0;
   bit cmp_en       = 1'b1;

   int         lat;
   int         nval;
   int         samp;
   logic [7:0] code;
   logic       busy0;
   logic       te0;

   sar_logic #(.NBITS(8), .SAMPLE_CYCLES(2), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .vop         (vop),
      .done        (done),
      .asyn_clk    (asyn_clk),
      .sample      (sample),
      .dac_p       (dac_p),
      .dac_n       (dac_n),
      .dout        (dout),
      .valid       (valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Ideal comparator: decides 1 time unit after the strobe rises,
   // resets 1 time unit after it falls.
   initial begin
      vop  = 1'b0;
      done = 1'b0;
   end
   always @(posedge asyn_clk) begin
      strobe_cnt++;
      if (cmp_en) begin
         #1;
         vop  = (vin >= int'(dac_p));
         done = 1'b1;
      end
   end
   always @(negedge asyn_clk) begin
      #1;
      done = 1'b0;
   end

   // Pulse start, then observe 1 time unit after each edge for up to limit
   // cycles; optional extra start pulses sampled at edges ign_a / ign_b.
   task automatic run_conv(input int limit, input bit run_full, input int ign_a, input int ign_b);
      start = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      strobe_cnt = 0;
      busy0      = busy;
      te0        = timeout_err;
      samp       = sample ? 1 : 0;
      lat        = -1;
      nval       = 0;
      code       = 8'hxx;
      for (int n = 1; n <= limit; n++) begin
         @(posedge clk);
         #1;
         if (sample) samp++;
         start = ((n == ign_a - 1) || (n == ign_b - 1));
         if (valid) begin
            nval++;
            if (lat < 0) begin
               lat  = n;
               code = dout;
            end
            if (!run_full) break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      rst = 1'b1;
      #1;
      tests_run++; if (asyn_clk !== 1'b0) begin tests_failed++; $display("FAIL rst_asyn_clk got %b want 0", asyn_clk); end
      tests_run++; if (sample !== 1'b0) begin tests_failed++; $display("FAIL rst_sample got %b want 0", sample); end
      tests_run++; if (valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rst_flags got v=%b b=%b t=%b want 000", valid, busy, timeout_err); end
      tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL rst_dout got %h want 00", dout); end
      tests_run++; if (dac_p !== 8'h00 || dac_n !== 8'hFF) begin tests_failed++; $display("FAIL rst_dac got p=%h n=%h want p=00 n=ff", dac_p, dac_n); end
      strobe_cnt = 0;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      tests_run++; if (strobe_cnt !== 0) begin tests_failed++; $display("FAIL rst_no_strobe got %0d want 0", strobe_cnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_start_ignored busy got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_nominal;
      vin = 8'h5A;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL nom_busy_edge0 got %b want 1", busy0); end
      tests_run++; if (lat !== 51) begin tests_failed++; $display("FAIL nom_latency got %0d want 51", lat); end
      tests_run++; if (code !== 8'h5A) begin tests_failed++; $display("FAIL nom_dout got %h want 5a", code); end
      tests_run++; if (strobe_cnt !== 8) begin tests_failed++; $display("FAIL nom_strobes got %0d want 8", strobe_cnt); end
      tests_run++; if (samp !== 2) begin tests_failed++; $display("FAIL nom_sample_cycles got %0d want 2", samp); end
      tests_run++; if (dac_p !== 8'h5A || dac_n !== 8'hA5) begin tests_failed++; $display("FAIL nom_dac got p=%h n=%h want p=5a n=a5", dac_p, dac_n); end
      tests_run++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL nom_flags got t=%b b=%b want t=0 b=0", timeout_err, busy); end
      @(posedge clk);
      #1;
      tests_run++; if (valid !== 1'b0 || dac_p !== 8'h5A) begin tests_failed++; $display("FAIL nom_after got v=%b p=%h want v=0 p=5a", valid, dac_p); end
   endtask

   task automatic test_extremes;
      vin = 1000;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (lat !== 51 || code !== 8'hFF) begin tests_failed++; $display("FAIL ext_high got lat=%0d code=%h want lat=51 code=ff", lat, code); end
      vin = -1000;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (lat !== 51 || code !== 8'h00) begin tests_failed++; $display("FAIL ext_low got lat=%0d code=%h want lat=51 code=00", lat, code); end
   endtask

   task automatic test_timeout;
      cmp_en = 1'b0;
      vin    = 8'h5A;
      run_conv(300, 1'b0, -10, -10);
      tests_run++; if (lat !== 243) begin tests_failed++; $display("FAIL to_latency got %0d want 243", lat); end
      tests_run++; if (code !== 8'h00) begin tests_failed++; $display("FAIL to_dout got %h want 00", code); end
      tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL to_err got %b want 1", timeout_err); end
      tests_run++; if (strobe_cnt !== 8) begin tests_failed++; $display("FAIL to_strobes got %0d want 8", strobe_cnt); end
      cmp_en = 1'b1;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (te0 !== 1'b0) begin tests_failed++; $display("FAIL to_clear got %b want 0", te0); end
      tests_run++; if (lat !== 51 || code !== 8'h5A || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_recover got lat=%0d code=%h t=%b want 51 5a 0", lat, code, timeout_err); end
   endtask

   task automatic test_ignored_start;
      vin = 8'h5A;
      run_conv(90, 1'b1, 5, 30);
      tests_run++; if (nval !== 1) begin tests_failed++; $display("FAIL ign_valid_count got %0d want 1", nval); end
      tests_run++; if (lat !== 51 || code !== 8'h5A) begin tests_failed++; $display("FAIL ign_result got lat=%0d code=%h want 51 5a", lat, code); end
   endtask

   task automatic test_reset_mid;
      int nv;
      vin = 8'h33;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // bit 4 strobe is high from edge 20 through edge 22
      repeat (21) @(posedge clk);
      #1;
      tests_run++; if (asyn_clk !== 1'b1) begin tests_failed++; $display("FAIL mid_in_comp_hi got %b want 1", asyn_clk); end
      #2;
      rst = 1'b1;
      #1;
      tests_run++; if (asyn_clk !== 1'b0 || busy !== 1'b0 || dac_n !== 8'hFF || dac_p !== 8'h00 || dout !== 8'h00) begin tests_failed++; $display("FAIL mid_rst_vals got a=%b b=%b p=%h n=%h d=%h want 0 0 00 ff 00", asyn_clk, busy, dac_p, dac_n, dout); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      nv = 0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk);
         #1;
         if (valid) nv++;
      end
      tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL mid_no_valid got %0d want 0", nv); end
      vin = 8'h5A;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (lat !== 51 || code !== 8'h5A) begin tests_failed++; $display("FAIL mid_recover got lat=%0d code=%h want 51 5a", lat, code); end
   endtask

   task automatic test_back_to_back;
      vin = 8'hC3;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (lat !== 51 || code !== 8'hC3) begin tests_failed++; $display("FAIL b2b_first got lat=%0d code=%h want 51 c3", lat, code); end
      vin = 8'h33;
      run_conv(100, 1'b0, -10, -10);
      tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got busy=%b want 1", busy0); end
      tests_run++; if (lat !== 51 || code !== 8'h33) begin tests_failed++; $display("FAIL b2b_second got lat=%0d code=%h want 51 33", lat, code); end
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_nominal;
      test_extremes;
      test_timeout;
      test_ignored_start;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
